pipe_hazard_ctrl: RTL and testbench

// - Hazard and forwarding controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
// - Tracks every instruction issued past ID in a DEPTH-entry scoreboard (entry 1=EX .. DEPTH=WB).
// - From the scoreboard it drives:
//   - PC / IF-ID stall,
//   - ID-EX bubble,
//   - IF-ID flush on EX redirect,
//   - per-operand forward selects.
// - Counts stall and flush cycles for performance measurement.

---
 rtl/pipe_hazard_ctrl.sv | 105 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage pipeline, driven by a post-ID scoreboard.
// Define HAZARD_FWD_EN for the forwarding build; otherwise the block interlocks until producers retire.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 32,
    localparam int SW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic              id_rs1_used,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rf_en,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    output logic              stall_fd,
    output logic              bubble_de,
    output logic              flush_fd,
    output logic [SW-1:0]     fwd_a,
    output logic [SW-1:0]     fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [DEPTH:1]    vld_q, vld_d;
    logic [DEPTH:1]    wr_q, wr_d;
    logic [DEPTH:1]    ld_q, ld_d;
    logic [REG_AW-1:0] rd_q [1:DEPTH];
    logic [REG_AW-1:0] rd_d [1:DEPTH];
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [DEPTH:1]    match_a, match_b;
    logic              hazard;

    // wr already excludes x0 producers; the explicit source check keeps x0 readers clean too.
    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            match_a[k] = vld_q[k] && wr_q[k] && id_rs1_used && (id_rs1 != '0) && (rd_q[k] == id_rs1);
            match_b[k] = vld_q[k] && wr_q[k] && id_rs2_used && (id_rs2 != '0) && (rd_q[k] == id_rs2);
        end
    end

    always_comb begin
        hazard = 1'b0;
        fwd_a  = '0;
        fwd_b  = '0;
`ifdef HAZARD_FWD_EN
        hazard = id_valid && ld_q[1] && (match_a[1] || match_b[1]);
        // Walk oldest to youngest so the youngest matching producer wins.
        for (int k = DEPTH; k >= 1; k--) begin
            if (match_a[k]) fwd_a = SW'(k);
            if (match_b[k]) fwd_b = SW'(k);
        end
`else
        hazard = id_valid && (|(match_a | match_b));
`endif
        stall_fd  = hazard && !ex_redirect;
        bubble_de = hazard || ex_redirect;
        flush_fd  = ex_redirect;
    end

    always_comb begin
        vld_d[1] = id_valid && !bubble_de;
        wr_d[1]  = id_rf_en && (id_rd != '0);
        ld_d[1]  = id_is_load;
        rd_d[1]  = id_rd;
        for (int k = 2; k <= DEPTH; k++) begin
            vld_d[k] = vld_q[k-1];
            wr_d[k]  = wr_q[k-1];
            ld_d[k]  = ld_q[k-1];
            rd_d[k]  = rd_q[k-1];
        end
        stall_cnt_d = (stall_fd && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush_fd && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            vld_q       <= vld_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Payload fields are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        wr_q <= wr_d;
        ld_q <= ld_d;
        rd_q <= rd_d;
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl; adapts expectations to the HAZARD_FWD_EN build.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int DEPTH   = 3;
    localparam int CNT_MAX = 15;
    localparam int NS_LOAD = FWD ? 1 : DEPTH;
    localparam int NS_ALU  = FWD ? 0 : DEPTH;

    typedef struct {
        logic       stall;
        logic       bubble;
        logic       flush;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] sc;
        logic [3:0] fc;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1_used, id_rs2_used, id_rf_en, id_is_load, ex_redirect;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       stall_fd, bubble_de, flush_fd;
    logic [1:0] fwd_a, fwd_b;
    logic [3:0] stall_cnt, flush_cnt;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   m_sc   = 0;
    int   m_fc   = 0;

    pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(DEPTH), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_rf_en(id_rf_en), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .stall_fd(stall_fd), .bubble_de(bubble_de), .flush_fd(flush_fd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, expv);
        end
    endtask

    // One pipeline cycle: drive ID at negedge, queue the expectation, sample before the next posedge.
    task automatic step(input logic v, input int rs1, input logic u1, input int rs2, input logic u2,
                        input int rd, input logic wr, input logic ld, input logic redir,
                        input logic es, input logic eb, input logic ef, input int fa, input int fb,
                        input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        id_valid = v;  id_rs1 = rs1[4:0]; id_rs1_used = u1;
        id_rs2 = rs2[4:0]; id_rs2_used = u2; id_rd = rd[4:0];
        id_rf_en = wr; id_is_load = ld; ex_redirect = redir;
        e.stall = es; e.bubble = eb; e.flush = ef;
        e.fa = fa[1:0]; e.fb = fb[1:0];
        e.sc = m_sc[3:0]; e.fc = m_fc[3:0]; e.tag = tag;
        exp_q.push_back(e);
        #2;
        got = exp_q.pop_front();
        chk(got.tag, "stall_fd",  32'(stall_fd),  32'(got.stall));
        chk(got.tag, "bubble_de", 32'(bubble_de), 32'(got.bubble));
        chk(got.tag, "flush_fd",  32'(flush_fd),  32'(got.flush));
        chk(got.tag, "fwd_a",     32'(fwd_a),     32'(got.fa));
        chk(got.tag, "fwd_b",     32'(fwd_b),     32'(got.fb));
        chk(got.tag, "stall_cnt", 32'(stall_cnt), 32'(got.sc));
        chk(got.tag, "flush_cnt", 32'(flush_cnt), 32'(got.fc));
        if (got.stall && m_sc < CNT_MAX) m_sc++;
        if (got.flush && m_fc < CNT_MAX) m_fc++;
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH; i++) idle("drain");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_sc = 0;
        m_fc = 0;
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
        id_rd = 0; id_rf_en = 0; id_is_load = 0; ex_redirect = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        idle("reset_state");

        // add x5 then add x6,x5,x7
        step(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, "alu_prod");
        for (int i = 0; i < NS_ALU; i++)
            step(1, 5, 1, 7, 1, 6, 1, 0, 0, 1, 1, 0, 0, 0, "alu_wait");
        step(1, 5, 1, 7, 1, 6, 1, 0, 0, 0, 0, 0, FWD ? 1 : 0, 0, "alu_fwd");
        drain();

        // lw x5 then add x6,x5,x5
        step(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, "lw_prod");
        for (int i = 0; i < NS_LOAD; i++)
            step(1, 5, 1, 5, 1, 6, 1, 0, 0, 1, 1, 0, FWD ? 1 : 0, FWD ? 1 : 0, "load_use");
        step(1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, FWD ? 2 : 0, FWD ? 2 : 0, "load_fwd");
        drain();

        // x0 producer never matches
        step(1, 1, 1, 2, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, "x0_prod");
        step(1, 0, 1, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, "x0_read");
        drain();

        // load-use hazard coinciding with a redirect; killed add x6 must not enter
        step(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, "redir_lw");
        step(1, 5, 1, 7, 0, 6, 1, 0, 1, 0, 1, 1, FWD ? 1 : 0, 0, "redir_hz");
        step(1, 6, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, "killed_rd");
        drain();

        // producer sitting in WB
        step(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, "wb_prod");
        idle("wb_gap1");
        idle("wb_gap2");
        for (int i = 0; i < (FWD ? 0 : 1); i++)
            step(1, 5, 1, 0, 0, 6, 1, 0, 0, 1, 1, 0, 0, 0, "wb_wait");
        step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, FWD ? 3 : 0, 0, "wb_fwd");
        drain();

        // two x5 writers: the youngest wins, rs2 resolved independently
        step(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, "yng_prod1");
        step(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, "yng_prod2");
        for (int i = 0; i < NS_ALU; i++)
            step(1, 5, 1, 9, 1, 6, 1, 0, 0, 1, 1, 0, 0, 0, "yng_wait");
        step(1, 5, 1, 9, 1, 6, 1, 0, 0, 0, 0, 0, FWD ? 1 : 0, 0, "yng_fwd");
        drain();

        // repeated load-use pairs drive the 4-bit stall counter into saturation
        for (int p = 0; p < 16; p++) begin
            step(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, "sat_lw");
            for (int i = 0; i < NS_LOAD; i++)
                step(1, 5, 1, 5, 1, 6, 1, 0, 0, 1, 1, 0, FWD ? 1 : 0, FWD ? 1 : 0, "sat_stall");
            step(1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, FWD ? 2 : 0, FWD ? 2 : 0, "sat_issue");
            drain();
        end
        idle("sat_hold");
        chk("sat_final", "stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));

        // reset in the middle of a load-use stall
        step(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, "rst_lw");
        step(1, 5, 1, 5, 1, 6, 1, 0, 0, 1, 1, 0, FWD ? 1 : 0, FWD ? 1 : 0, "rst_stall");
        do_reset();
        step(1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, "after_rst");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
